// File: rtl/mem_loader_if.sv
// Byte-stream / instruction-memory-write bundle for mem_loader.
// master = byte source and controller, slave = the loader itself.
interface mem_loader_if #(
  parameter int unsigned BIT_ADDR = 32,
  parameter int unsigned BIT_DATO = 32
);
  logic                start;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic [BIT_ADDR-1:0] addrW;
  logic [BIT_DATO-1:0] datW;
  logic                memWrite;
  logic                busy;
  logic                done;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, addrW, datW, memWrite, busy, done
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, addrW, datW, memWrite, busy, done
  );
endinterface

// File: rtl/mem_loader.sv
// Assembles little-endian program bytes into BIT_DATO-wide words and writes
// NWORDS of them to instruction memory at consecutive word addresses.
module mem_loader #(
  parameter int unsigned BIT_ADDR = 32,
  parameter int unsigned BIT_DATO = 32,
  parameter int unsigned NWORDS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_loader_if.slave bus
);
  localparam int unsigned BYTES = BIT_DATO / 8;
  localparam int unsigned CW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       word_cnt_q, word_cnt_d;
  logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [BIT_DATO-1:0] asm_q, asm_d, asm_merged;
  logic [BIT_ADDR-1:0] addr_q, addr_d;
  logic [BIT_DATO-1:0] dat_q, dat_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_write_q, mem_write_d;
  logic                accept;

  // ready_q is high exactly in COLLECT, so this also masks byte_valid elsewhere
  assign accept = ready_q & bus.byte_valid;

  always_comb begin
    asm_merged = asm_q;
    asm_merged[{byte_cnt_q, 3'b000} +: 8] = bus.byte_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = COLLECT;
      COLLECT:    if (accept && byte_cnt_q == LAST_BYTE) state_d = WRITE;
      WRITE:      state_d = (word_cnt_q == LAST_WORD) ? DONE : COLLECT;
      default:    state_d = IDLE;
    endcase
  end

  // Write address/data are captured on the final byte so they are already
  // registered during the single WRITE cycle and simply hold afterwards.
  always_comb begin
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          word_cnt_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          asm_d = asm_merged;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            addr_d     = BIT_ADDR'(word_cnt_q);
            dat_d      = asm_merged;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (word_cnt_q != LAST_WORD) word_cnt_d = word_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_d     = (state_d == COLLECT);
    busy_d      = (state_d == COLLECT) || (state_d == WRITE);
    done_d      = (state_d == DONE);
    mem_write_d = (state_d == WRITE);
  end

  assign bus.byte_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.memWrite   = mem_write_q;
  assign bus.addrW      = addr_q;
  assign bus.datW       = dat_q;
endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a byte driver plus a monitor that predicts
// each write from the byte stream the bench itself generated.
module tb_mem_loader;
  localparam int BA = 32;
  localparam int BD = 32;
  localparam int NW = 16;
  localparam int NB = BD / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_loader_if #(.BIT_ADDR(BA), .BIT_DATO(BD)) bus ();

  mem_loader #(.BIT_ADDR(BA), .BIT_DATO(BD), .NWORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Program image for the current session; word k is bytes k*NB..k*NB+NB-1, LSB first.
  logic [7:0] stream [NW*NB];

  function automatic logic [BD-1:0] pack_word(input int unsigned k);
    logic [BD-1:0] w;
    w = '0;
    for (int j = 0; j < NB; j++) w[8*j +: 8] = stream[k*NB + j];
    return w;
  endfunction

  task automatic fill_stream();
    for (int i = 0; i < NW*NB; i++) stream[i] = 8'($urandom);
  endtask

  // Monitor: counts accepted bytes; every NB-th one must produce a strobe next cycle.
  bit          mon_en = 1'b0;
  bit          exp_strobe = 1'b0;
  int unsigned n_acc = 0;
  int unsigned n_strobe = 0;
  int unsigned cyc = 0;
  int unsigned strobe_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      n_acc = 0; n_strobe = 0; exp_strobe = 1'b0; strobe_cyc.delete();
    end else if (mon_en) begin
      check("memWrite", bus.memWrite, exp_strobe);
      if (bus.memWrite) begin
        if (n_strobe < NW) begin
          check("addrW", bus.addrW, 64'(n_strobe));
          check("datW", bus.datW, pack_word(n_strobe));
        end else begin
          check("extra_strobe", n_strobe, NW - 1);
        end
        check("ready_in_write", bus.byte_ready, 0);
        check("busy_in_write", bus.busy, 1);
        strobe_cyc.push_back(cyc);
        n_strobe++;
      end
      exp_strobe = 1'b0;
      if (bus.byte_valid && bus.byte_ready) begin
        n_acc++;
        if (n_acc % NB == 0) exp_strobe = 1'b1;
      end
      if (bus.start && !bus.busy) begin
        n_acc = 0; n_strobe = 0; exp_strobe = 1'b0; strobe_cyc.delete();
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Sends stream[0..n-1]; gaps of 0..gap_max idle cycles, forced 10-cycle
  // mid-word gaps when long_gaps, and random start pulses inside gaps when noise.
  task automatic send_bytes(input int unsigned n, input int unsigned gap_max,
                            input bit long_gaps, input bit noise);
    int unsigned g, budget;
    for (int i = 0; i < int'(n); i++) begin
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      if (long_gaps && (i % NB == 2) && ((i / NB) % 4 == 1)) g = 10;
      for (int c = 0; c < int'(g); c++) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        bus.start      = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        @(posedge clk); #1;
      end
      bus.start      = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_in    = stream[i];
      budget = 0;
      forever begin
        @(negedge clk);
        if (bus.byte_ready) break;
        budget++;
        if (budget > 20) begin
          check("ready_timeout", 0, 1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned k;
    k = 0;
    while (bus.done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus.done, 1);
    check({tag, "_strobes"}, n_strobe, NW);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_addrW"}, bus.addrW, 0);
    check({tag, "_datW"}, bus.datW, 0);
    check({tag, "_memWrite"}, bus.memWrite, 0);
    check({tag, "_ready"}, bus.byte_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_cleared("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);
    check("idle_ready", bus.byte_ready, 0);

    // Single known word
    fill_stream();
    stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h10; stream[3] = 8'h00;
    do_start();
    send_bytes(4, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("first_count", n_strobe, 1);
    check("first_addrW", bus.addrW, 0);
    check("first_datW", bus.datW, 32'h00100513);
    pulse_reset();

    // start together with byte_valid in IDLE: that byte must not be taken
    fill_stream();
    stream[0] = 8'h5A;
    bus.byte_valid = 1'b1; bus.byte_in = 8'hAA; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    send_bytes(NW*NB, 0, 1'b0, 1'b0);
    wait_done("done_s1");

    // Restart from DONE, continuous stream
    repeat (5) @(negedge clk);
    check("done_holds", bus.done, 1);
    fill_stream();
    do_start();
    check("restart_done_clr", bus.done, 0);
    check("restart_busy", bus.busy, 1);
    send_bytes(NW*NB, 0, 1'b0, 1'b0);
    wait_done("done_s2");
    check("strobe_n", strobe_cyc.size(), NW);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check("spacing", strobe_cyc[i] - strobe_cyc[i-1], NB + 1);

    // Random stalls, long mid-word gaps, stray start pulses
    fill_stream();
    do_start();
    send_bytes(NW*NB, 3, 1'b1, 1'b1);
    wait_done("done_s3");

    // Reset in the middle of word 3
    fill_stream();
    do_start();
    send_bytes(3*NB + 2, 0, 1'b0, 1'b0);
    check("pre_reset_strobes", n_strobe, 3);
    #1 rst = 1'b0;
    #1 check_cleared("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.byte_valid = 1'b1; bus.byte_in = 8'hC3;
    repeat (5) @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    check("post_reset_ready", bus.byte_ready, 0);
    check("post_reset_strobes", n_strobe, 0);
    do_start();
    send_bytes(NW*NB, 1, 1'b0, 1'b0);
    wait_done("done_s4");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
